// File: rtl/dccm_port_ctrl.sv
// dccm_port_ctrl
//   Responder-side controller for the core's DCCM port. Serialises the core's
//   independent same-cycle read and write requests onto one single-port
//   synchronous SRAM. Reads win the SRAM port; writes are parked in a
//   circular posted-write buffer and drained into SRAM cycles no read needs.
//
//   Build option: define DCCM_FWD_EN to forward read data from the posted-write
//   buffer. Without it, a read that hits a buffered write stalls (dccm_busy)
//   until the matching entries have drained, then reads the SRAM.
//
// Ports
//   clk, rst_n      core clock, asynchronous active-low reset
//   dccm_wr_*       write request: enable, byte address, full-word data
//   dccm_rd_*       read request: enable, byte address; rd_data/rd_valid
//                   return one cycle after acceptance
//   dccm_busy       requests are not accepted this cycle; core holds them
//   sram_*          single-port synchronous SRAM (word addressed, AW bits);
//                   sram_rdata is valid the cycle after a read cycle
module dccm_port_ctrl #(
  parameter int unsigned AW       = 14,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dccm_wr_en,
  input  logic [31:0]   dccm_wr_addr,
  input  logic [31:0]   dccm_wr_data,
  input  logic          dccm_rd_en,
  input  logic [31:0]   dccm_rd_addr,
  output logic [31:0]   dccm_rd_data,
  output logic          dccm_rd_valid,
  output logic          dccm_busy,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam int unsigned PW       = $clog2(WB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WB_DEPTH);

  // Posted-write buffer
  logic [AW-1:0] wb_addr [WB_DEPTH];
  logic [31:0]   wb_data [WB_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          run;
  logic [AW-1:0] rd_waddr;
  logic [AW-1:0] wr_waddr;
  logic          full;
  logic          empty;
  logic          match;
  logic          hazard;
  logic          rd_acc;
  logic          wr_acc;
  logic          fwd_sel;
  logic          sram_rd;
  logic          push;
  logic          pop;
  logic          rd_valid_q;
  logic [31:0]   rd_src;
  logic [31:0]   rd_last_q;

  logic          unused_addr_bits;

  assign rd_waddr = dccm_rd_addr[AW+1:2];
  assign wr_waddr = dccm_wr_addr[AW+1:2];
  assign unused_addr_bits = ^{dccm_rd_addr[31:AW+2], dccm_rd_addr[1:0],
                              dccm_wr_addr[31:AW+2], dccm_wr_addr[1:0]};

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

`ifdef DCCM_FWD_EN
  logic [31:0] match_data;
  logic        fwd_q;
  logic [31:0] fwd_data_q;
`endif

  // Walk valid entries oldest to youngest; the last hit seen is the youngest.
  // Entries pushed at the coming edge are not in the buffer yet, so a
  // same-cycle write is naturally excluded.
  always_comb begin
    match = 1'b0;
`ifdef DCCM_FWD_EN
    match_data = '0;
`endif
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (wb_addr[head + PW'(i)] == rd_waddr)) begin
        match = 1'b1;
`ifdef DCCM_FWD_EN
        match_data = wb_data[head + PW'(i)];
`endif
      end
    end
  end

`ifdef DCCM_FWD_EN
  assign hazard = 1'b0;
`else
  // Read-after-write hazard: hold the read (and any write) until drained.
  assign hazard = dccm_rd_en & match;
`endif

  // While rst_n is high but no edge has yet seen it high, hold the core off so
  // no request is accepted and no SRAM cycle is issued.
  assign dccm_busy = (rst_n & ~run) | full | hazard;

  assign rd_acc = run & dccm_rd_en & ~dccm_busy;
  assign wr_acc = run & dccm_wr_en & ~dccm_busy;

`ifdef DCCM_FWD_EN
  assign fwd_sel = rd_acc & match;
`else
  assign fwd_sel = 1'b0;
`endif

  assign sram_rd = rd_acc & ~fwd_sel;
  assign push    = wr_acc;
  assign pop     = ~sram_rd & ~empty;

  // SRAM port arbitration
  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (sram_rd) begin
      sram_ce   = 1'b1;
      sram_addr = rd_waddr;
    end else if (pop) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = wb_addr[head];
      sram_wdata = wb_data[head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage needs no reset: only entries below count are ever used.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= wr_waddr;
      wb_data[tail] <= dccm_wr_data;
    end
  end

  // Read return path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
    end
  end

`ifdef DCCM_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q <= fwd_sel;
      if (fwd_sel) fwd_data_q <= match_data;
    end
  end

  assign rd_src = fwd_q ? fwd_data_q : sram_rdata;
`else
  assign rd_src = sram_rdata;
`endif

  // sram_rdata only arrives in the return cycle, so the output is a mux
  // between the live source and a copy of the last returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last_q <= '0;
    end else if (rd_valid_q) begin
      rd_last_q <= rd_src;
    end
  end

  assign dccm_rd_valid = rd_valid_q;
  assign dccm_rd_data  = rd_valid_q ? rd_src : rd_last_q;

endmodule
